demux4_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_lane_reg.sv | 39 +++
 rtl/demux4_stream.sv | 64 ++++++
 tb/tb_demux4_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 stream distributor.
package demux_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SEL_Y0 = 2'b00;
    localparam logic [1:0] SEL_Y1 = 2'b01;
    localparam logic [1:0] SEL_Y2 = 2'b10;
    localparam logic [1:0] SEL_Y3 = 2'b11;

    // One-hot lane strobe for a 2-bit destination select.
    function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [1:0] sel);
        return NUM_LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output buffer for a single lane, with a delivered-word counter.
// EMPTY/FULL is carried by 'valid'; a drain and a load may share a cycle.
module demux_lane_reg #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNTW-1:0]  cnt,
    output logic             can_load
);

    // A new word fits when the slot is empty or is being drained this cycle.
    assign can_load = !valid || ready;

    // Buffer state: load wins over drain; data is held (not cleared) after drain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= din;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (valid && ready)
                cnt <= cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream distributor: routes each accepted word to the lane
// named by in_sel. Each lane stalls independently of the others.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [WIDTH-1:0]     y0,
    output logic [WIDTH-1:0]     y1,
    output logic [WIDTH-1:0]     y2,
    output logic [WIDTH-1:0]     y3,
    output logic [NUM_LANES-1:0] y_valid,
    input  logic [NUM_LANES-1:0] y_ready,
    output logic                 busy,
    output logic [CNTW-1:0]      cnt0,
    output logic [CNTW-1:0]      cnt1,
    output logic [CNTW-1:0]      cnt2,
    output logic [CNTW-1:0]      cnt3
);

    logic [NUM_LANES-1:0]            lane_load;
    logic [NUM_LANES-1:0]            lane_can_load;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0][CNTW-1:0]  lane_cnt;

    // Only the selected lane gates acceptance; held low during reset.
    assign in_ready  = resetn && lane_can_load[in_sel];
    assign lane_load = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane_reg #(
            .WIDTH (WIDTH),
            .CNTW  (CNTW)
        ) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .load     (lane_load[i]),
            .din      (in_data),
            .ready    (y_ready[i]),
            .valid    (y_valid[i]),
            .data     (lane_data[i]),
            .cnt      (lane_cnt[i]),
            .can_load (lane_can_load[i])
        );
    end

    assign y0   = lane_data[SEL_Y0];
    assign y1   = lane_data[SEL_Y1];
    assign y2   = lane_data[SEL_Y2];
    assign y3   = lane_data[SEL_Y3];
    assign cnt0 = lane_cnt[SEL_Y0];
    assign cnt1 = lane_cnt[SEL_Y1];
    assign cnt2 = lane_cnt[SEL_Y2];
    assign cnt3 = lane_cnt[SEL_Y3];
    assign busy = |y_valid;

endmodule

// File: tb/tb_demux4_stream.sv
// Scoreboard bench for demux4_stream: stimulus pushes expected words per lane,
// a negedge monitor pops them on every lane transfer and checks hold stability.
module tb_demux4_stream;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic        busy;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;

    demux4_stream #(.WIDTH(32), .CNTW(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .busy     (busy),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ys [4];
    logic [7:0]  cs [4];
    always_comb begin
        ys = '{y0, y1, y2, y3};
        cs = '{cnt0, cnt1, cnt2, cnt3};
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q [4][$];
    logic [7:0]  exp_cnt [4];
    bit          last_acc = 0;
    logic [1:0]  last_sel;
    logic [31:0] last_data;

    task automatic check(input logic [63:0] act, input logic [63:0] exp, input string name);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every lane transfer must match the oldest queued word; a lane
    // that was stalled last cycle must still show the same word.
    bit          hold [4];
    logic [31:0] held [4];
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) hold[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i]) begin
                    check(64'(y_valid[i]), 64'd1, $sformatf("lane%0d_stable_valid", i));
                    check(64'(ys[i]), 64'(held[i]), $sformatf("lane%0d_stable_data", i));
                end
                if (y_valid[i] && y_ready[i]) begin
                    if (q[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL lane%0d_extra: got word %0h expected no transfer", i, ys[i]);
                    end else begin
                        check(64'(ys[i]), 64'(q[i].pop_front()), $sformatf("lane%0d_data", i));
                    end
                end
                hold[i] = y_valid[i] && !y_ready[i];
                held[i] = ys[i];
            end
        end
    end

    // One clock of stimulus. er: expected in_ready (0/1) or -1 for don't-care.
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] s, input int er);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        @(negedge clk);
        if (last_acc) begin
            check(64'(y_valid[last_sel]), 64'd1, "latency_valid");
            check(64'(ys[last_sel]), 64'(last_data), "latency_data");
        end
        last_acc = 0;
        if (er >= 0) check(64'(in_ready), 64'(er), "in_ready");
        if (v && er == 1) begin
            q[s].push_back(d);
            exp_cnt[s] = exp_cnt[s] + 8'd1;
            last_acc  = 1;
            last_sel  = s;
            last_data = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'd0, -1);
    endtask

    task automatic chk_state(input logic [3:0] ev, input bit zero_y);
        check(64'(y_valid), 64'(ev), "y_valid");
        check(64'(busy), 64'(|ev), "busy");
        for (int i = 0; i < 4; i++) begin
            check(64'(cs[i]), 64'(exp_cnt[i]), $sformatf("cnt%0d", i));
            if (zero_y) check(64'(ys[i]), 64'd0, $sformatf("y%0d_reset", i));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
        resetn   = 1'b0;
        y_ready  = 4'b0000;
        in_valid = 1'b1;
        in_data  = 32'hFFFF;
        in_sel   = 2'd2;

        // Reset held 3 cycles with a word on offer: nothing accepted.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'hFFFF, 2'(k), 0);
            chk_state(4'b0000, 1);
        end
        resetn = 1'b1;

        // Basic routing, one word per lane back-to-back.
        y_ready = 4'b1111;
        step(1'b1, 32'hA000_0000, 2'd0, 1);
        step(1'b1, 32'h0000_00B1, 2'd1, 1);
        step(1'b1, 32'h0000_00C2, 2'd2, 1);
        step(1'b1, 32'h0000_00D3, 2'd3, 1);
        idle();
        chk_state(4'b0000, 0);
        check(64'(cnt0), 64'd1, "route_cnt0");
        check(64'(cnt3), 64'd1, "route_cnt3");

        // Backpressure isolation on lane 2.
        y_ready = 4'b1011;
        step(1'b1, 32'h11, 2'd2, 1);
        step(1'b1, 32'h22, 2'd2, 0);
        step(1'b1, 32'h33, 2'd0, 1);
        idle();
        check(64'(y_valid), 64'b0100, "stall_valid");
        check(64'(y2), 64'h11, "stall_y2");
        check(64'(y0), 64'h33, "stall_y0");
        y_ready = 4'b1111;
        idle();
        step(1'b1, 32'h22, 2'd2, 1);
        idle();
        chk_state(4'b0000, 0);

        // Drain and load on lane 1 in the same cycle.
        y_ready = 4'b1101;
        step(1'b1, 32'h5, 2'd1, 1);
        idle();
        step(1'b1, 32'h7, 2'd1, 0);
        y_ready = 4'b1111;
        step(1'b1, 32'h6, 2'd1, 1);
        idle();
        chk_state(4'b0000, 0);
        check(64'(cnt1), 64'd3, "dl_cnt1");

        // 256 words to lane 3: counter wraps back to its starting value.
        for (int k = 0; k < 256; k++)
            step(1'b1, 32'h300 + 32'(k), 2'd3, 1);
        idle();
        chk_state(4'b0000, 0);
        check(64'(cnt3), 64'd1, "wrap_cnt3");

        // Reset while lanes 0 and 3 hold stalled words.
        y_ready = 4'b0110;
        step(1'b1, 32'hE0, 2'd0, 1);
        step(1'b1, 32'hE3, 2'd3, 1);
        idle();
        check(64'(y_valid), 64'b1001, "pre_reset_valid");
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            exp_cnt[i] = 8'd0;
        end
        step(1'b1, 32'h77, 2'd1, 0);
        resetn = 1'b1;
        chk_state(4'b0000, 1);
        y_ready = 4'b1111;
        idle();
        idle();
        idle();
        chk_state(4'b0000, 1);

        for (int i = 0; i < 4; i++)
            check(64'(q[i].size()), 64'd0, $sformatf("lane%0d_leftover", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
